// File: rtl/microseq_pkg.sv
// Shared definitions for the microprogrammed sequencer.
//   - default parameter values (DEF_*)
//   - next-address mode encoding (mode_e)
//   - microword field offsets for the default configuration
//   - mk_uword(): packs one microword, used when building microcode images
// Microword fields, MSB to LSB: N[2:0], INV, SEL, MOORE, TGT.
package microseq_pkg;

    localparam int unsigned DEF_STATE_W     = 7;
    localparam int unsigned DEF_CTRL_W      = 26;
    localparam int unsigned DEF_NCOND       = 4;
    localparam int unsigned DEF_SEL_W       = $clog2(DEF_NCOND);
    localparam int unsigned DEF_FETCH_ADDR  = 1;
    localparam int unsigned DEF_STACK_DEPTH = 4;
    localparam int unsigned DEF_DEPTH       = 2 ** DEF_STATE_W;

    localparam int unsigned N_W       = 3;
    localparam int unsigned TGT_LSB   = 0;
    localparam int unsigned MOORE_LSB = TGT_LSB + DEF_STATE_W;
    localparam int unsigned SEL_LSB   = MOORE_LSB + DEF_CTRL_W;
    localparam int unsigned INV_BIT   = SEL_LSB + DEF_SEL_W;
    localparam int unsigned N_LSB     = INV_BIT + 1;
    localparam int unsigned UWORD_W   = N_LSB + N_W;

    typedef enum logic [2:0] {
        M_DISPATCH = 3'd0,
        M_FETCH    = 3'd1,
        M_JUMP     = 3'd2,
        M_INCR     = 3'd3,
        M_CJUMP    = 3'd4,
        M_CWAIT    = 3'd5,
        M_CALL     = 3'd6,
        M_RET      = 3'd7
    } mode_e;

    // Assemble one microword for the default configuration.
    function automatic logic [UWORD_W-1:0] mk_uword(
        input mode_e                  n,
        input logic                   inv,
        input logic [DEF_SEL_W-1:0]   sel,
        input logic [DEF_CTRL_W-1:0]  moore,
        input logic [DEF_STATE_W-1:0] tgt
    );
        return {n, inv, sel, moore, tgt};
    endfunction

endpackage

// File: rtl/microseq_stack.sv
// Microsubroutine return stack (LIFO) for the sequencer.
// Ports:
//   clk, reset     clock, async active-low reset (clears pointer and err)
//   i_push, i_pop  push i_data / drop top entry (never both at once)
//   i_data         return address to push
//   o_top_c        current top entry (combinational)
//   o_empty_c      stack empty (combinational)
//   o_err          sticky overflow/underflow flag
module microseq_stack #(
    parameter int unsigned DATA_W = 7,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_top_c,
    output logic              o_empty_c,
    output logic              o_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_sp;
    logic              r_err;
    logic              w_full;

    assign w_full    = (r_sp == PTR_W'(DEPTH));
    assign o_empty_c = (r_sp == '0);
    assign o_top_c   = r_mem[IDX_W'(r_sp - PTR_W'(1))];
    assign o_err     = r_err;

    // Pointer and sticky error; a rejected push/pop leaves the pointer alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sp  <= '0;
            r_err <= 1'b0;
        end else if (i_push) begin
            if (w_full) r_err <= 1'b1;
            else        r_sp  <= r_sp + PTR_W'(1);
        end else if (i_pop) begin
            if (o_empty_c) r_err <= 1'b1;
            else           r_sp  <= r_sp - PTR_W'(1);
        end
    end

    // Entry storage; contents are meaningless once the pointer is reset.
    always_ff @(posedge clk) begin
        if (i_push && !w_full) r_mem[IDX_W'(r_sp)] <= i_data;
    end

endmodule

// File: rtl/microseq_unit.sv
// Microprogrammed sequencer: writable microstore, registered microword,
// next-address selection (dispatch, fetch, jump, incr, conditional jump/wait,
// optional call/return).
// Optional feature macro: MICROSEQ_STACK_EN (enables CALL/RET return stack;
// when undefined CALL acts as JUMP, RET as FETCH and stack_err is 0).
// Ports:
//   clk            clock, all state on rising edge
//   reset          async active-low reset
//   dispatch_addr  decoded opcode entry address
//   cond_in        condition inputs
//   ucode_we/addr/wdata  microstore write port (read-before-write)
//   ctrl           MOORE field of the current microword
//   cur_state      current microaddress
//   stack_err      sticky stack overflow/underflow flag
module microseq_unit
    import microseq_pkg::*;
#(
    parameter int unsigned STATE_W     = DEF_STATE_W,
    parameter int unsigned CTRL_W      = DEF_CTRL_W,
    parameter int unsigned NCOND       = DEF_NCOND,
    parameter int unsigned FETCH_ADDR  = DEF_FETCH_ADDR,
    parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH,
    localparam int unsigned SEL_W      = $clog2(NCOND),
    localparam int unsigned W          = 3 + 1 + SEL_W + CTRL_W + STATE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] dispatch_addr,
    input  logic [NCOND-1:0]   cond_in,
    input  logic               ucode_we,
    input  logic [STATE_W-1:0] ucode_addr,
    input  logic [W-1:0]       ucode_wdata,
    output logic [CTRL_W-1:0]  ctrl,
    output logic [STATE_W-1:0] cur_state,
    output logic               stack_err
);

    localparam int unsigned DEPTH   = 2 ** STATE_W;
    localparam int unsigned CV_W    = 2 ** SEL_W;
    localparam int unsigned F_TGT   = 0;
    localparam int unsigned F_MOORE = F_TGT + STATE_W;
    localparam int unsigned F_SEL   = F_MOORE + CTRL_W;
    localparam int unsigned F_INV   = F_SEL + SEL_W;
    localparam int unsigned F_N     = F_INV + 1;

    // Pointer arithmetic in the return stack relies on a power-of-two depth.
    if (STACK_DEPTH == 0 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_stack_depth
        $error("STACK_DEPTH must be a nonzero power of two");
    end

    logic [W-1:0]       r_mem [DEPTH];
    logic [W-1:0]       r_word;
    logic [STATE_W-1:0] r_state;
    logic               r_boot;

    logic [STATE_W-1:0] w_next;
    logic [STATE_W-1:0] w_inc;
    logic [STATE_W-1:0] w_tgt;
    logic [SEL_W-1:0]   w_sel;
    logic [CV_W-1:0]    w_cond_vec;
    logic               w_sts;
    mode_e              w_mode;

`ifdef MICROSEQ_STACK_EN
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_err;
    logic [STATE_W-1:0] w_top;
`endif

    assign w_tgt  = r_word[F_TGT +: STATE_W];
    assign w_sel  = r_word[F_SEL +: SEL_W];
    assign w_mode = mode_e'(r_word[F_N +: 3]);
    assign w_inc  = r_state + STATE_W'(1);

    // Zero-padding makes any SEL at or beyond NCOND read as condition 0.
    assign w_cond_vec = CV_W'(cond_in);
    assign w_sts      = w_cond_vec[w_sel] ^ r_word[F_INV];

    // Next-address select; the boot edge overrides everything to address 0.
    always_comb begin
        w_next = w_inc;
`ifdef MICROSEQ_STACK_EN
        w_push = 1'b0;
        w_pop  = 1'b0;
`endif
        if (r_boot) begin
            w_next = '0;
        end else begin
            case (w_mode)
                M_DISPATCH: w_next = dispatch_addr;
                M_FETCH:    w_next = STATE_W'(FETCH_ADDR);
                M_JUMP:     w_next = w_tgt;
                M_INCR:     w_next = w_inc;
                M_CJUMP:    w_next = w_sts ? w_tgt : w_inc;
                M_CWAIT:    w_next = w_sts ? w_inc : r_state;
`ifdef MICROSEQ_STACK_EN
                M_CALL: begin
                    w_push = 1'b1;
                    w_next = w_tgt;
                end
                M_RET: begin
                    w_pop  = 1'b1;
                    w_next = w_empty ? STATE_W'(FETCH_ADDR) : w_top;
                end
`else
                M_CALL:     w_next = w_tgt;
                M_RET:      w_next = STATE_W'(FETCH_ADDR);
`endif
                default:    w_next = w_inc;
            endcase
        end
    end

    // Microstore write port; a same-edge fetch sees the old contents.
    always_ff @(posedge clk) begin
        if (ucode_we) r_mem[ucode_addr] <= ucode_wdata;
    end

    // Microword / microaddress registers and boot flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word  <= '0;
            r_state <= '0;
            r_boot  <= 1'b1;
        end else begin
            r_word  <= r_mem[w_next];
            r_state <= w_next;
            r_boot  <= 1'b0;
        end
    end

    assign ctrl      = r_word[F_MOORE +: CTRL_W];
    assign cur_state = r_state;

`ifdef MICROSEQ_STACK_EN
    microseq_stack #(
        .DATA_W (STATE_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_data    (w_inc),
        .o_top_c   (w_top),
        .o_empty_c (w_empty),
        .o_err     (w_err)
    );
    assign stack_err = w_err;
`else
    assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_microseq_unit.sv
// Self-checking bench for microseq_unit: directed microprograms followed by
// randomized microcode, conditions, writes and resets, all compared against a
// behavioural model (array microstore, queue return stack).
module tb_microseq_unit;
    import microseq_pkg::*;

    localparam int unsigned W  = UWORD_W;
    localparam int unsigned SW = DEF_STATE_W;
    localparam int unsigned CW = DEF_CTRL_W;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] dispatch_addr;
    logic [DEF_NCOND-1:0] cond_in;
    logic          ucode_we;
    logic [SW-1:0] ucode_addr;
    logic [W-1:0]  ucode_wdata;
    logic [CW-1:0] ctrl;
    logic [SW-1:0] cur_state;
    logic          stack_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [W-1:0]  m_mem [DEF_DEPTH];
    logic [W-1:0]  m_word;
    logic [SW-1:0] m_state;
    bit            m_boot;
    bit            m_err;
    int            m_stk[$];

    microseq_unit dut (
        .clk           (clk),
        .reset         (reset),
        .dispatch_addr (dispatch_addr),
        .cond_in       (cond_in),
        .ucode_we      (ucode_we),
        .ucode_addr    (ucode_addr),
        .ucode_wdata   (ucode_wdata),
        .ctrl          (ctrl),
        .cur_state     (cur_state),
        .stack_err     (stack_err)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] mo(input int a);
        return CW'(32'h0150_0000 + a);
    endfunction

    function automatic logic [W-1:0] uw(input mode_e n, input int inv, input int sel,
                                        input int tgt, input int a);
        return mk_uword(n, 1'(inv), DEF_SEL_W'(sel), mo(a), SW'(tgt));
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = '0;
        m_word  = '0;
        m_boot  = 1'b1;
        m_err   = 1'b0;
        m_stk.delete();
    endtask

    // One rising edge of the reference sequencer.
    task automatic model_edge();
        int  mode, sel, tgt, inc, nxt;
        bit  c, sts;
        if (reset) begin
            mode = int'(m_word[N_LSB +: N_W]);
            sel  = int'(m_word[SEL_LSB +: DEF_SEL_W]);
            tgt  = int'(m_word[TGT_LSB +: SW]);
            c    = (sel < DEF_NCOND) ? cond_in[sel] : 1'b0;
            sts  = c ^ m_word[INV_BIT];
            inc  = (int'(m_state) + 1) % DEF_DEPTH;
            nxt  = inc;
            if (m_boot) begin
                nxt    = 0;
                m_boot = 1'b0;
            end else begin
                case (mode)
                    0: nxt = int'(dispatch_addr);
                    1: nxt = DEF_FETCH_ADDR;
                    2: nxt = tgt;
                    3: nxt = inc;
                    4: nxt = sts ? tgt : inc;
                    5: nxt = sts ? inc : int'(m_state);
                    6: begin
`ifdef MICROSEQ_STACK_EN
                        if (m_stk.size() < DEF_STACK_DEPTH) m_stk.push_back(inc);
                        else m_err = 1'b1;
`endif
                        nxt = tgt;
                    end
                    default: begin
`ifdef MICROSEQ_STACK_EN
                        if (m_stk.size() > 0) nxt = m_stk.pop_back();
                        else begin
                            m_err = 1'b1;
                            nxt   = DEF_FETCH_ADDR;
                        end
`else
                        nxt = DEF_FETCH_ADDR;
`endif
                    end
                endcase
            end
            m_state = SW'(nxt);
            m_word  = m_mem[nxt];
        end
        if (ucode_we) m_mem[ucode_addr] = ucode_wdata;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("cur_state", 64'(cur_state), 64'(m_state));
        check_eq("ctrl", 64'(ctrl), 64'(m_word[MOORE_LSB +: CW]));
        check_eq("stack_err", 64'(stack_err), 64'(m_err));
    endtask

    task automatic step_exp(input string tag, input int exp_state);
        step();
        check_eq(tag, 64'(cur_state), 64'(exp_state));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        check_eq("rst_state", 64'(cur_state), 64'd0);
        check_eq("rst_ctrl", 64'(ctrl), 64'd0);
        check_eq("rst_err", 64'(stack_err), 64'd0);
    endtask

    task automatic wr(input int a, input logic [W-1:0] d);
        ucode_we    = 1'b1;
        ucode_addr  = SW'(a);
        ucode_wdata = d;
        step();
        ucode_we    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cond_in = '0; dispatch_addr = '0;
        ucode_we = 1'b0; ucode_addr = '0; ucode_wdata = '0;
        model_reset();
        #2;

        // Baseline image plus the directed microprogram, loaded under reset.
        do_reset();
        for (int a = 0; a < int'(DEF_DEPTH); a++) wr(a, uw(M_JUMP, 0, 0, 0, a));
        wr(0,  uw(M_FETCH, 0, 0, 0, 0));
        wr(1,  uw(M_INCR,  0, 0, 0, 1));
        wr(2,  uw(M_JUMP,  0, 0, 5, 2));
        wr(5,  uw(M_CWAIT, 0, 0, 0, 5));
        wr(6,  uw(M_JUMP,  0, 0, 3, 6));
        wr(3,  uw(M_CJUMP, 1, 1, 40, 3));
        wr(40, uw(M_JUMP,  0, 0, 3, 40));
        wr(4,  uw(M_JUMP,  0, 0, 10, 4));
        wr(10, uw(M_CALL,  0, 0, 50, 10));
        wr(50, uw(M_CALL,  0, 0, 60, 50));
        wr(60, uw(M_CALL,  0, 0, 70, 60));
        wr(70, uw(M_CALL,  0, 0, 80, 70));
        wr(80, uw(M_CALL,  0, 0, 90, 80));
        wr(90, uw(M_RET,   0, 0, 0, 90));
        wr(71, uw(M_RET,   0, 0, 0, 71));
        wr(61, uw(M_RET,   0, 0, 0, 61));
        wr(51, uw(M_RET,   0, 0, 0, 51));
        wr(11, uw(M_RET,   0, 0, 0, 11));
        reset = 1'b1;

        step_exp("boot", 0);
        step_exp("fetch", 1);
        step_exp("incr", 2);
        step_exp("jump", 5);
        for (int i = 0; i < 3; i++) step_exp("cwait_hold", 5);
        check_eq("cwait_ctrl", 64'(ctrl), 64'(mo(5)));
        cond_in[0] = 1'b1;
        step_exp("cwait_go", 6);
        step_exp("jump3", 3);
        cond_in[1] = 1'b0;
        step_exp("cjump_taken", 40);
        step_exp("jump3b", 3);
        cond_in[1] = 1'b1;
        step_exp("cjump_fall", 4);
        step_exp("to_call", 10);
        step_exp("call1", 50);
        step_exp("call2", 60);
        step_exp("call3", 70);
        step_exp("call4", 80);
        step_exp("call5", 90);
`ifdef MICROSEQ_STACK_EN
        check_eq("overflow_err", 64'(stack_err), 64'd1);
        step_exp("ret1", 71);
        step_exp("ret2", 61);
        step_exp("ret3", 51);
        step_exp("ret4", 11);
        step_exp("ret_underflow", DEF_FETCH_ADDR);
        check_eq("err_sticky", 64'(stack_err), 64'd1);
`else
        step_exp("ret_as_fetch", DEF_FETCH_ADDR);
        check_eq("err_tied", 64'(stack_err), 64'd0);
`endif

        // Increment wrap at the top of the microstore.
        do_reset();
        wr(2,   uw(M_JUMP, 0, 0, 126, 2));
        wr(126, uw(M_INCR, 0, 0, 0, 126));
        wr(127, uw(M_INCR, 0, 0, 0, 127));
        reset = 1'b1;
        step_exp("w_boot", 0);
        step_exp("w_fetch", 1);
        step_exp("w_incr", 2);
        step_exp("w_jump", 126);
        step_exp("w_127", 127);
        step_exp("wrap", 0);

        // Dispatch, then read-before-write on the fetched address.
        do_reset();
        wr(2,  uw(M_DISPATCH, 0, 0, 0, 2));
        wr(64, uw(M_JUMP, 0, 0, 9, 64));
        wr(9,  uw(M_JUMP, 0, 0, 9, 9));
        dispatch_addr = SW'(64);
        reset = 1'b1;
        step_exp("d_boot", 0);
        step_exp("d_fetch", 1);
        step_exp("d_incr", 2);
        step_exp("dispatch", 64);
        check_eq("dispatch_ctrl", 64'(ctrl), 64'(mo(64)));
        ucode_we = 1'b1; ucode_addr = SW'(9); ucode_wdata = uw(M_JUMP, 0, 0, 9, 200);
        step_exp("rbw_addr", 9);
        ucode_we = 1'b0;
        check_eq("rbw_old", 64'(ctrl), 64'(mo(9)));
        step();
        check_eq("rbw_new", 64'(ctrl), 64'(mo(200)));

        // Random microcode, conditions, writes and resets.
        do_reset();
        for (int a = 0; a < int'(DEF_DEPTH); a++) wr(a, W'({$urandom(), $urandom()}));
        reset = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            cond_in       = DEF_NCOND'($urandom());
            dispatch_addr = SW'($urandom());
            ucode_we      = ($urandom_range(7) == 0);
            ucode_addr    = SW'($urandom());
            ucode_wdata   = W'({$urandom(), $urandom()});
            if ($urandom_range(249) == 0) begin
                do_reset();
                step();
                reset = 1'b1;
            end else begin
                step();
            end
        end
        ucode_we = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
